// File: rtl/router_a_ctrl.sv
// Router A select-line sequencer: arbitrates host access, ALU write-back and bank clear sweep.
// Optional RA_CTRL_RR_EN: round-robin between alu_req and host_req (default: fixed alu > host).
module router_a_ctrl #(
    parameter int unsigned ADDRW   = 5,
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic             host_rw,
    input  logic [ADDRW-1:0] host_addr,
    output logic             host_ack,
    input  logic             alu_req,
    input  logic             READY,
    output logic             alu_ack,
    output logic             alu_err,
    input  logic             clr_req,
    output logic             clr_done,
    output logic             busy,
    output logic [1:0]       sel_data,
    output logic             sel_dira,
    output logic             sel_dirb,
    output logic [1:0]       sel_write,
    output logic [ADDRW-1:0] dir_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOST   = 2'd1,
        ALU_WB = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [ADDRW-1:0] CNT_MAX = '1;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

    state_t           state, state_d;
    logic [TMO_W-1:0] tmo, tmo_d;
    logic [ADDRW-1:0] cnt, cnt_d;
    logic [ADDRW-1:0] haddr_q, haddr_d;
    logic             hrw_q, hrw_d;
    logic             alu_win, host_win;

    logic             host_ack_d, alu_ack_d, alu_err_d, clr_done_d, busy_d;
    logic [1:0]       sel_data_d, sel_write_d;
    logic             sel_dira_d, sel_dirb_d;
    logic [ADDRW-1:0] dir_out_d;

`ifdef RA_CTRL_RR_EN
    logic last_alu, last_alu_d;

    always_comb begin
        alu_win  = alu_req & (~host_req | ~last_alu);
        host_win = host_req & ~alu_win;
    end
`else
    always_comb begin
        alu_win  = alu_req;
        host_win = host_req & ~alu_req;
    end
`endif

    // Everything below is computed for the upcoming cycle, so the registered
    // pulses and selects line up with the state cycle they describe.
    always_comb begin
        state_d    = state;
        tmo_d      = tmo;
        cnt_d      = cnt;
        haddr_d    = haddr_q;
        hrw_d      = hrw_q;
        host_ack_d = 1'b0;
        alu_ack_d  = 1'b0;
        alu_err_d  = 1'b0;
        clr_done_d = 1'b0;
`ifdef RA_CTRL_RR_EN
        last_alu_d = last_alu;
`endif
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_done_d = (CNT_MAX == '0);
                end else if (alu_win) begin
                    state_d   = ALU_WB;
                    tmo_d     = '0;
                    alu_ack_d = READY;
                    alu_err_d = ~READY & (TMO_LIM == '0);
`ifdef RA_CTRL_RR_EN
                    last_alu_d = 1'b1;
`endif
                end else if (host_win) begin
                    state_d    = HOST;
                    haddr_d    = host_addr;
                    hrw_d      = host_rw;
                    host_ack_d = 1'b1;
`ifdef RA_CTRL_RR_EN
                    last_alu_d = 1'b0;
`endif
                end
            end
            HOST: state_d = IDLE;
            ALU_WB: begin
                if (alu_ack || alu_err) begin
                    state_d = IDLE;
                end else begin
                    tmo_d     = tmo + 1'b1;
                    alu_ack_d = READY;
                    alu_err_d = ~READY & (tmo_d == TMO_LIM);
                end
            end
            CLEAR: begin
                cnt_d = cnt + 1'b1;
                if (clr_done) state_d = IDLE;
                else          clr_done_d = (cnt_d == CNT_MAX);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data_d  = 2'd0;
        sel_dira_d  = 1'b0;
        sel_dirb_d  = 1'b0;
        sel_write_d = 2'd2;
        dir_out_d   = '0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            HOST: begin
                dir_out_d = haddr_d;
                if (hrw_d) begin
                    sel_dira_d  = 1'b1;
                    sel_write_d = 2'd3;
                end else begin
                    sel_dirb_d = 1'b1;
                end
            end
            ALU_WB: begin
                sel_data_d  = 2'd1;
                sel_write_d = 2'd1;
            end
            CLEAR: begin
                sel_data_d  = 2'd2;
                sel_dira_d  = 1'b1;
                sel_write_d = 2'd3;
                dir_out_d   = cnt_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo       <= '0;
            cnt       <= '0;
            haddr_q   <= '0;
            hrw_q     <= 1'b0;
            host_ack  <= 1'b0;
            alu_ack   <= 1'b0;
            alu_err   <= 1'b0;
            clr_done  <= 1'b0;
            busy      <= 1'b0;
            sel_data  <= 2'd0;
            sel_dira  <= 1'b0;
            sel_dirb  <= 1'b0;
            sel_write <= 2'd2;
            dir_out   <= '0;
`ifdef RA_CTRL_RR_EN
            last_alu  <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            tmo       <= tmo_d;
            cnt       <= cnt_d;
            haddr_q   <= haddr_d;
            hrw_q     <= hrw_d;
            host_ack  <= host_ack_d;
            alu_ack   <= alu_ack_d;
            alu_err   <= alu_err_d;
            clr_done  <= clr_done_d;
            busy      <= busy_d;
            sel_data  <= sel_data_d;
            sel_dira  <= sel_dira_d;
            sel_dirb  <= sel_dirb_d;
            sel_write <= sel_write_d;
            dir_out   <= dir_out_d;
`ifdef RA_CTRL_RR_EN
            last_alu  <= last_alu_d;
`endif
        end
    end

endmodule

// File: tb/tb_router_a_ctrl.sv
// Scoreboard bench for router_a_ctrl: expected handshake pulses are queued by the stimulus
// and popped by a monitor; per-cycle select checks are made inline by the stimulus.
module tb_router_a_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_req = 1'b0, host_rw = 1'b0;
    logic [4:0] host_addr = '0;
    logic       alu_req = 1'b0, READY = 1'b0, clr_req = 1'b0;
    logic       host_ack, alu_ack, alu_err, clr_done, busy;
    logic [1:0] sel_data, sel_write;
    logic       sel_dira, sel_dirb;
    logic [4:0] dir_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] kind;   // 0 host_ack, 1 alu_ack, 2 alu_err, 3 clr_done
        logic [1:0] sd;
        logic       da;
        logic       db;
        logic [1:0] sw;
        logic [4:0] dir;
    } exp_t;

    exp_t sb[$];

    router_a_ctrl #(.ADDRW(5), .TMO_W(4), .TMO_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_ack(host_ack),
        .alu_req(alu_req), .READY(READY), .alu_ack(alu_ack), .alu_err(alu_err),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .sel_data(sel_data), .sel_dira(sel_dira), .sel_dirb(sel_dirb),
        .sel_write(sel_write), .dir_out(dir_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {sel_data, sel_dira, sel_dirb, sel_write, dir_out, busy, host_ack, alu_ack, alu_err, clr_done}
    function automatic logic [15:0] snap();
        return {sel_data, sel_dira, sel_dirb, sel_write, dir_out, busy,
                host_ack, alu_ack, alu_err, clr_done};
    endfunction

    localparam logic [15:0] IDLE_VEC = {2'd0, 1'b0, 1'b0, 2'd2, 5'd0, 1'b0, 4'b0000};

    function automatic exp_t mk(input logic [1:0] k, input logic [1:0] sd, input logic da,
                                input logic db, input logic [1:0] sw, input logic [4:0] dir);
        exp_t e;
        e.kind = k; e.sd = sd; e.da = da; e.db = db; e.sw = sw; e.dir = dir;
        return e;
    endfunction

    // Monitor: every handshake pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (host_ack || alu_ack || alu_err || clr_done) begin
            exp_t act;
            act.kind = clr_done ? 2'd3 : alu_err ? 2'd2 : alu_ack ? 2'd1 : 2'd0;
            act.sd = sel_data; act.da = sel_dira; act.db = sel_dirb;
            act.sw = sel_write; act.dir = dir_out;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {19'd0, act}, 32'h0000_ffff);
            end else begin
                check("pulse_event", {19'd0, act}, {19'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ackd;
        // 1: reset state held while idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_after_reset", {16'd0, snap()}, {16'd0, IDLE_VEC});
        end

        // 2: host write then host read
        host_req = 1'b1; host_rw = 1'b1; host_addr = 5'h12;
        sb.push_back(mk(2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 5'h12));
        @(negedge clk);
        host_req = 1'b0;
        check("host_wr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("idle_after_host", {16'd0, snap()}, {16'd0, IDLE_VEC});
        host_req = 1'b1; host_rw = 1'b0; host_addr = 5'h07;
        sb.push_back(mk(2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 5'h07));
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);

        // 3a: ALU write-back, READY after three waiting cycles
        alu_req = 1'b1; READY = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("alu_wb_sel", {28'd0, sel_data, sel_write}, {28'd0, 2'd1, 2'd1});
            check("alu_wb_pulses", {30'd0, alu_ack, alu_err}, {30'd0, (k == 4), 1'b0});
            if (k == 3) begin
                READY = 1'b1;
                sb.push_back(mk(2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
            end
        end
        alu_req = 1'b0; READY = 1'b0;
        @(negedge clk);
        check("idle_after_alu", {16'd0, snap()}, {16'd0, IDLE_VEC});

        // 3b: ALU write-back timeout after TMO_MAX+1 cycles
        alu_req = 1'b1;
        sb.push_back(mk(2'd2, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("alu_tmo_pulses", {29'd0, busy, alu_ack, alu_err}, {29'd0, 1'b1, 1'b0, (k == 16)});
        end
        alu_req = 1'b0;
        @(negedge clk);
        check("idle_after_tmo", {16'd0, snap()}, {16'd0, IDLE_VEC});

        // 4a: full clear sweep
        clr_req = 1'b1;
        sb.push_back(mk(2'd3, 2'd2, 1'b1, 1'b0, 2'd3, 5'd31));
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            clr_req = 1'b0;
            check("clear_cycle", {21'd0, sel_data, sel_dira, sel_write, dir_out, clr_done},
                  {21'd0, 2'd2, 1'b1, 2'd3, k[4:0], (k == 31)});
        end
        @(negedge clk);
        check("idle_after_clear", {16'd0, snap()}, {16'd0, IDLE_VEC});

        // 4b: reset in the middle of a sweep
        clr_req = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            clr_req = 1'b0;
        end
        check("clear_at_10", {27'd0, dir_out}, 32'd10);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_clear", {16'd0, snap()}, {16'd0, IDLE_VEC});
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_mid_reset", {16'd0, snap()}, {16'd0, IDLE_VEC});

        // 5: alu and host held together, four grants one every other cycle
        do_reset();
        alu_req = 1'b1; host_req = 1'b1; host_rw = 1'b1; host_addr = 5'h0A; READY = 1'b1;
`ifdef RA_CTRL_RR_EN
        sb.push_back(mk(2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
        sb.push_back(mk(2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 5'h0A));
        sb.push_back(mk(2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
        sb.push_back(mk(2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 5'h0A));
`else
        for (int g = 0; g < 4; g++) sb.push_back(mk(2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
`endif
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("arb_busy_pattern", {31'd0, busy}, {31'd0, (k % 2 == 1)});
        end
        alu_req = 1'b0; host_req = 1'b0;
        repeat (2) @(negedge clk);
        check("arb_drained", sb.size(), 32'd0);

        // 6: all three together; clear wins, alu then host served after clr_done
        clr_req = 1'b1; alu_req = 1'b1; host_req = 1'b1; host_addr = 5'h15; READY = 1'b1;
        sb.push_back(mk(2'd3, 2'd2, 1'b1, 1'b0, 2'd3, 5'd31));
        sb.push_back(mk(2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 5'd0));
        sb.push_back(mk(2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 5'h15));
        @(negedge clk);
        clr_req = 1'b0;
        check("clear_first", {30'd0, sel_data}, 32'd2);
        ackd = 1'b0;
        for (int k = 0; k < 100 && !ackd; k++) begin
            @(negedge clk);
            if (alu_ack) alu_req = 1'b0;
            if (host_ack) host_req = 1'b0;
            ackd = !alu_req && !host_req;
        end
        check("all_served", {31'd0, ackd}, 32'd1);
        alu_req = 1'b0; host_req = 1'b0; READY = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_at_end", {16'd0, snap()}, {16'd0, IDLE_VEC});
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
